// File: rtl/spi_flash_reader_pkg.sv
// Shared serial-flash definitions: opcodes, frame sizes and the reader FSM state encoding.
package spi_flash_reader_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_RDID  = 8'h9F;
    localparam int         CMD_BITS  = 8;
    localparam int         ADDR_BITS = 24;
    localparam int         HDR_BITS  = CMD_BITS + ADDR_BITS;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_CMD      = 3'd2,
        ST_ADDR     = 3'd3,
        ST_DATA     = 3'd4,
        ST_CS_HOLD  = 3'd5
    } rd_state_e;

    function automatic logic is_shifting(rd_state_e s);
        return (s == ST_CMD) || (s == ST_ADDR) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/spi_flash_reader_sck_gen.sv
// Mode-0 SPI clock generator: half-period tick every CLK_DIV clk, SPICLK register and edge strobes.
module spi_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic run_i,
    output logic tick_o,
    output logic rise_o,
    output logic fall_o,
    output logic sck_o
);

    localparam int               DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             sck_q, sck_d;

    always_comb begin
        tick_o    = (div_cnt_q == '0);
        div_cnt_d = div_cnt_q - DIV_W'(1);
        // clear realigns the half-period to the start of a new frame
        if (clear_i || tick_o) begin
            div_cnt_d = DIV_RELOAD;
        end
        rise_o = run_i && tick_o && !sck_q;
        fall_o = run_i && tick_o && sck_q;
        sck_d  = sck_q ^ (run_i && tick_o);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q <= '0;
            sck_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            sck_q     <= sck_d;
        end
    end

    assign sck_o = sck_q;

endmodule

// File: rtl/spi_flash_reader.sv
// Serial-flash READ (0x03 + 24-bit address) controller streaming back len bytes.
// state     | meaning
// IDLE      | CS high, waiting for start
// CS_SETUP  | CS low, SPICLK low one half-period, opcode MSB on MOSI
// CMD       | 8 SPICLK pulses shifting the opcode
// ADDR      | 24 SPICLK pulses shifting the address
// DATA      | 8*len pulses receiving bytes, one rd_valid per byte
// CS_HOLD   | SPICLK low one half-period, then CS high and done
module spi_flash_reader
    import spi_flash_reader_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [23:0]      addr,
    input  logic [LEN_W-1:0] len,
    input  logic             SPIMISO,
    output logic             SPICLK,
    output logic             SPIMOSI,
    output logic             chip_select,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = LEN_W + 6;

    logic [1:0]          rst_sync_q;
    logic                rst_int_n;
    rd_state_e           state_q, state_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [HDR_BITS-1:0] shift_out_q, shift_out_d;
    logic [7:0]          shift_in_q, shift_in_d;
    logic [7:0]          rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                cs_q, cs_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                sck_clear, sck_tick, sck_rise, sck_fall;
    logic [CNT_W-1:0]    data_bits;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    spi_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk     (clk),
        .reset_n (rst_int_n),
        .clear_i (sck_clear),
        .run_i   (is_shifting(state_q)),
        .tick_o  (sck_tick),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall),
        .sck_o   (SPICLK)
    );

    // rem_q counts SPICLK rising edges still to come in the frame
    assign data_bits = CNT_W'({len_q, 3'b000});

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        len_d       = len_q;
        shift_out_d = shift_out_q;
        shift_in_d  = shift_in_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        cs_d        = cs_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        sck_clear   = 1'b0;

        if (sck_rise) begin
            shift_in_d = {shift_in_q[6:0], SPIMISO};
            rem_d      = rem_q - CNT_W'(1);
        end
        if (sck_fall) begin
            shift_out_d = {shift_out_q[HDR_BITS-2:0], 1'b0};
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start && !done_q) begin
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        len_d       = len;
                        rem_d       = CNT_W'(HDR_BITS) + CNT_W'({len, 3'b000});
                        shift_out_d = {CMD_READ, addr};
                        cs_d        = 1'b0;
                        busy_d      = 1'b1;
                        sck_clear   = 1'b1;
                        state_d     = ST_CS_SETUP;
                    end
                end
            end
            ST_CS_SETUP: begin
                if (sck_tick) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (sck_rise && (rem_q == data_bits + CNT_W'(ADDR_BITS + 1))) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (sck_rise && (rem_q == data_bits + CNT_W'(1))) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (sck_rise && (rem_q[2:0] == 3'd1)) begin
                    rd_data_d  = {shift_in_q[6:0], SPIMISO};
                    rd_valid_d = 1'b1;
                end
                if (sck_fall && (rem_q == '0)) begin
                    state_d = ST_CS_HOLD;
                end
            end
            ST_CS_HOLD: begin
                if (sck_tick) begin
                    cs_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            len_q       <= '0;
            shift_out_q <= '0;
            shift_in_q  <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            cs_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            len_q       <= len_d;
            shift_out_q <= shift_out_d;
            shift_in_q  <= shift_in_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            cs_q        <= cs_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign SPIMOSI     = shift_out_q[HDR_BITS-1];
    assign chip_select = cs_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: three instances (CLK_DIV 2, 1, 5) each talking to a mode-0 flash model.
`timescale 1ns/1ps
module tb_spi_flash_reader;

    localparam int NI    = 3;
    localparam int LEN_W = 8;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [NI-1:0]       start_v;
    logic [23:0]         addr_v;
    logic [LEN_W-1:0]    len_v;
    logic [NI-1:0]       miso_v, sck_v, mosi_v, cs_v, rdv_v, busy_v, done_v;
    logic [NI-1:0][7:0]  rdd_v;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        spi_flash_reader #(
            .CLK_DIV ((g == 0) ? 2 : ((g == 1) ? 1 : 5)),
            .LEN_W   (LEN_W)
        ) u_dut (
            .clk         (clk),
            .reset_n     (reset_n),
            .start       (start_v[g]),
            .addr        (addr_v),
            .len         (len_v),
            .SPIMISO     (miso_v[g]),
            .SPICLK      (sck_v[g]),
            .SPIMOSI     (mosi_v[g]),
            .chip_select (cs_v[g]),
            .rd_data     (rdd_v[g]),
            .rd_valid    (rdv_v[g]),
            .busy        (busy_v[g]),
            .done        (done_v[g])
        );
    end

    function automatic int half_per(int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 5);
    endfunction

    // Flash model and bus monitor, sampled on clk (SPICLK is a clk-domain register)
    int          n        [NI] = '{default: 0};
    logic [31:0] cap      [NI] = '{default: 32'h0};
    int          last_n   [NI] = '{default: 0};
    logic [31:0] last_cap [NI] = '{default: 32'h0};
    int          done_cnt [NI] = '{default: 0};
    int          rdv_cnt  [NI] = '{default: 0};
    int          csf_cnt  [NI] = '{default: 0};
    int          last_rise[NI] = '{default: 0};
    int          per_bad  [NI] = '{default: 0};
    int          busy_bad [NI] = '{default: 0};
    int          sck_bad  [NI] = '{default: 0};
    logic [7:0]  rx_mem   [NI][64];
    int          cycle = 0;
    logic [NI-1:0] sck_prev = '0;
    logic [NI-1:0] cs_prev  = '1;

    always @(posedge clk) begin
        cycle <= cycle + 1;
        for (int i = 0; i < NI; i++) begin
            if (cs_v[i]) begin
                n[i] <= 0;
            end else if (sck_v[i] && !sck_prev[i]) begin
                n[i] <= n[i] + 1;
                if (n[i] < 32) cap[i] <= {cap[i][30:0], mosi_v[i]};
                if (n[i] > 0 && (cycle - last_rise[i]) != 2 * half_per(i)) per_bad[i] <= per_bad[i] + 1;
                last_rise[i] <= cycle;
            end
            if (cs_v[i] && !cs_prev[i]) begin
                last_n[i]   <= n[i];
                last_cap[i] <= cap[i];
            end
            if (!cs_v[i] && cs_prev[i]) csf_cnt[i] <= csf_cnt[i] + 1;
            if (cs_v[i] && sck_v[i]) sck_bad[i] <= sck_bad[i] + 1;
            if ((!cs_v[i] && !busy_v[i]) || (done_v[i] && (busy_v[i] || !cs_v[i])))
                busy_bad[i] <= busy_bad[i] + 1;
            if (done_v[i]) done_cnt[i] <= done_cnt[i] + 1;
            if (rdv_v[i]) begin
                rx_mem[i][rdv_cnt[i][5:0]] <= rdd_v[i];
                rdv_cnt[i] <= rdv_cnt[i] + 1;
            end
        end
        sck_prev <= sck_v;
        cs_prev  <= cs_v;
    end

    // Flash returns byte addr[7:0]+k for the k-th data byte, MSB first
    always_comb begin
        int         j;
        logic [7:0] b;
        j      = 0;
        b      = '0;
        miso_v = '0;
        for (int i = 0; i < NI; i++) begin
            if (n[i] >= 32) begin
                j         = n[i] - 32;
                b         = cap[i][7:0] + 8'(j / 8);
                miso_v[i] = b[3'(7 - (j % 8))];
            end
        end
    end

    typedef struct packed {
        int          inst;
        logic [23:0] a;
        int          l;
        int          exp_rises;
        logic [31:0] exp_d;
    } vec_t;

    vec_t vecs [5];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int i, input int base, input string tag);
        int w;
        w = 0;
        while (done_cnt[i] == base && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check({tag, " done timeout"}, 32'(done_cnt[i] != base), 32'd1);
    endtask

    task automatic wait_bits(input int i, input int target, input string tag);
        int w;
        w = 0;
        while (n[i] != target && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check({tag, " bit wait"}, 32'(n[i]), 32'(target));
    endtask

    task automatic pulse_start(input int i, input logic [23:0] a, input int l);
        @(negedge clk);
        addr_v     = a;
        len_v      = LEN_W'(l);
        start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int i, d0, r0, sb0, bb0, pb0;
        i   = v.inst;
        d0  = done_cnt[i];
        r0  = rdv_cnt[i];
        sb0 = sck_bad[i];
        bb0 = busy_bad[i];
        pb0 = per_bad[i];
        pulse_start(i, v.a, v.l);
        wait_done(i, d0, tag);
        repeat (4) @(negedge clk);
        check({tag, " done count"}, 32'(done_cnt[i] - d0), 32'd1);
        check({tag, " rd_valid count"}, 32'(rdv_cnt[i] - r0), 32'(v.l));
        for (int k = 0; k < v.l; k++)
            check($sformatf("%s byte%0d", tag, k), 32'(rx_mem[i][6'(r0 + k)]), 32'(v.exp_d[31 - 8 * k -: 8]));
        check({tag, " mosi frame"}, last_cap[i], {8'h03, v.a});
        check({tag, " spiclk rises"}, 32'(last_n[i]), 32'(v.exp_rises));
        check({tag, " spiclk period"}, 32'(per_bad[i] - pb0), 32'd0);
        check({tag, " busy/cs framing"}, 32'(busy_bad[i] - bb0), 32'd0);
        check({tag, " sck with cs high"}, 32'(sck_bad[i] - sb0), 32'd0);
        check({tag, " idle cs/busy"}, {30'd0, cs_v[i], busy_v[i]}, 32'd2);
        check({tag, " rd_data held"}, 32'(rdd_v[i]), 32'(v.exp_d[31 - 8 * (v.l - 1) -: 8]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0, r0, c0, w;
        vecs[0] = '{inst: 0, a: 24'h000010, l: 1, exp_rises: 40, exp_d: 32'h10000000};
        vecs[1] = '{inst: 0, a: 24'h0A0BF0, l: 4, exp_rises: 64, exp_d: 32'hF0F1F2F3};
        vecs[2] = '{inst: 1, a: 24'h0A0BF0, l: 4, exp_rises: 64, exp_d: 32'hF0F1F2F3};
        vecs[3] = '{inst: 2, a: 24'h0A0BF0, l: 4, exp_rises: 64, exp_d: 32'hF0F1F2F3};
        vecs[4] = '{inst: 0, a: 24'h1234FE, l: 3, exp_rises: 56, exp_d: 32'hFEFF0000};

        start_v = '0;
        addr_v  = '0;
        len_v   = '0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++)
            check($sformatf("reset state inst%0d", i),
                  {18'd0, cs_v[i], sck_v[i], mosi_v[i], rdv_v[i], busy_v[i], done_v[i], rdd_v[i]},
                  {18'd0, 6'b100000, 8'h00});
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int k = 0; k < 5; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

        // zero-length request
        d0 = done_cnt[0];
        c0 = csf_cnt[0];
        pulse_start(0, 24'h00ABCD, 0);
        check("len0 done next cycle", 32'(done_v[0]), 32'd1);
        check("len0 busy low", 32'(busy_v[0]), 32'd0);
        @(negedge clk);
        check("len0 done one cycle", 32'(done_v[0]), 32'd0);
        repeat (10) @(negedge clk);
        check("len0 cs never low", 32'(csf_cnt[0] - c0), 32'd0);
        check("len0 done count", 32'(done_cnt[0] - d0), 32'd1);

        // start on the done cycle is dropped, start on the following cycle is taken
        d0 = done_cnt[0];
        pulse_start(0, 24'h000020, 1);
        w = 0;
        while (!done_v[0] && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check("done-cycle wait", 32'(done_v[0]), 32'd1);
        start_v[0] = 1'b1;
        @(negedge clk);
        check("start on done ignored", {30'd0, busy_v[0], cs_v[0]}, 32'd1);
        @(negedge clk);
        start_v[0] = 1'b0;
        check("start after done taken", {30'd0, busy_v[0], cs_v[0]}, 32'd2);
        wait_done(0, d0 + 1, "post-done txn");
        repeat (4) @(negedge clk);
        check("post-done rd_data", 32'(rdd_v[0]), 32'h20);

        // second start mid-ADDR is ignored
        d0 = done_cnt[0];
        r0 = rdv_cnt[0];
        pulse_start(0, 24'h000010, 1);
        wait_bits(0, 12, "midaddr");
        pulse_start(0, 24'h555555, 4);
        wait_done(0, d0, "midaddr");
        repeat (200) @(negedge clk);
        check("midaddr done count", 32'(done_cnt[0] - d0), 32'd1);
        check("midaddr rd_valid count", 32'(rdv_cnt[0] - r0), 32'd1);
        check("midaddr byte", 32'(rx_mem[0][6'(r0)]), 32'h10);
        check("midaddr mosi frame", last_cap[0], 32'h03000010);

        // reset during data byte 2 aborts at once
        d0 = done_cnt[0];
        r0 = rdv_cnt[0];
        pulse_start(0, 24'h0A0BF0, 4);
        wait_bits(0, 44, "abort");
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort cs/sck async", {30'd0, cs_v[0], sck_v[0]}, 32'd2);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (50) @(negedge clk);
        check("abort no done", 32'(done_cnt[0] - d0), 32'd0);
        check("abort one byte delivered", 32'(rdv_cnt[0] - r0), 32'd1);
        check("abort rd_data cleared", 32'(rdd_v[0]), 32'h00);
        run_vec(vecs[1], "after-abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
